supercar_ctrl: RTL

SUPERCAR_CTRL -- requirements
Module: supercar_ctrl

---
 rtl/supercar_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/supercar_ctrl.sv
// Knight-rider light sweep controller: drives an external N_BIT shift register
// so that a single lit bit bounces between its LSB and MSB.
module supercar_ctrl #(
  parameter int N_BIT   = 8,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PRESC_W-1:0] speed,
  input  logic [N_BIT-1:0]   pout,
  output logic               shr_en,
  output logic               shr_pl,
  output logic               shr_l_nr,
  output logic               shr_sin,
  output logic [N_BIT-1:0]   shr_pin,
  output logic               busy,
  output logic [7:0]         bounces
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [N_BIT-1:0]   PIN_ONE  = {{(N_BIT-1){1'b0}}, 1'b1};
  localparam logic [N_BIT-1:0]   PIN_ZERO = {N_BIT{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};

  state_t             state_r;
  state_t             state_nxt_s;
  logic               dir_r;       // 1 = moving left (towards MSB)
  logic               dir_nxt_s;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] spd_r;
  logic [7:0]         bounces_r;
  logic               tick_s;
  logic               bounce_s;
  logic               go_s;

  assign tick_s  = (state_r == RUN) && (presc_r == spd_r);
  assign go_s    = (state_r == IDLE) && start && !stop;
  assign shr_sin = 1'b0;
  assign bounces = bounces_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; stop wins over any pending tick
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (go_s) state_nxt_s = LOAD;
        else      state_nxt_s = IDLE;
      end
      LOAD: begin
        if (stop) state_nxt_s = CLEAR;
        else      state_nxt_s = RUN;
      end
      RUN: begin
        if (stop) state_nxt_s = CLEAR;
        else      state_nxt_s = RUN;
      end
      CLEAR:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode plus direction/bounce decisions taken on a tick
  always_comb begin
    shr_en    = 1'b0;
    shr_pl    = 1'b0;
    shr_l_nr  = dir_r;
    shr_pin   = PIN_ZERO;
    dir_nxt_s = dir_r;
    bounce_s  = 1'b0;
    case (state_r)
      IDLE: begin
        shr_en = 1'b0;
      end
      LOAD: begin
        shr_en    = 1'b1;
        shr_pl    = 1'b1;
        shr_pin   = PIN_ONE;
        dir_nxt_s = 1'b1;
      end
      RUN: begin
        if (tick_s && !stop) begin
          shr_en = 1'b1;
          if (pout == PIN_ZERO) begin
            // pattern lost: reseed and restart leftward
            shr_pl    = 1'b1;
            shr_pin   = PIN_ONE;
            shr_l_nr  = 1'b1;
            dir_nxt_s = 1'b1;
          end else if (dir_r) begin
            if (pout[N_BIT-1]) begin
              shr_l_nr  = 1'b0;
              dir_nxt_s = 1'b0;
              bounce_s  = 1'b1;
            end else begin
              shr_l_nr = 1'b1;
            end
          end else begin
            if (pout[0]) begin
              shr_l_nr  = 1'b1;
              dir_nxt_s = 1'b1;
              bounce_s  = 1'b1;
            end else begin
              shr_l_nr = 1'b0;
            end
          end
        end else begin
          shr_en = 1'b0;
        end
      end
      CLEAR: begin
        shr_en  = 1'b1;
        shr_pl  = 1'b1;
        shr_pin = PIN_ZERO;
      end
      default: begin
        shr_en = 1'b0;
      end
    endcase
  end

  assign busy = (state_r != IDLE);

  // Direction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r <= 1'b1;
    end else begin
      dir_r <= dir_nxt_s;
    end
  end

  // Step prescaler: counts 0..spd_r while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= PRESC_ZERO;
    end else if (state_r == LOAD) begin
      presc_r <= PRESC_ZERO;
    end else if (state_r == RUN) begin
      if (tick_s) presc_r <= PRESC_ZERO;
      else        presc_r <= presc_r + PRESC_ONE;
    end else begin
      presc_r <= presc_r;
    end
  end

  // Speed snapshot and reversal counter, both restarted by start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_r     <= PRESC_ZERO;
      bounces_r <= 8'd0;
    end else if (go_s) begin
      spd_r     <= speed;
      bounces_r <= 8'd0;
    end else if (bounce_s) begin
      bounces_r <= bounces_r + 8'd1;
    end else begin
      bounces_r <= bounces_r;
    end
  end

endmodule
